// File: rtl/mantissa_addsub_seq.sv
// mantissa_addsub_seq: chunk-serial mantissa add/sub returning a sign-magnitude result.
// Operands and the partial result shift right one chunk per cycle; a second pass negates negative differences.
module mantissa_addsub_seq #(
    parameter int MW    = 7,
    parameter int CHUNK = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] man_a,
    input  logic [MW-1:0] man_b,
    input  logic          sub,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW:0]   result,
    output logic          neg,
    output logic          zero
);
    localparam int N  = MW / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (MW % CHUNK != 0) begin : g_bad_chunk
        $error("MW must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         r_state;
    logic [MW-1:0]  r_a, r_b, r_low;
    logic           r_sub, r_carry, r_valid, r_neg, r_zero;
    logic [CW-1:0]  r_cnt;
    logic [MW:0]    r_result;
    logic [CHUNK-1:0] w_op_a, w_op_b;
    logic [CHUNK:0] w_sum;
    logic [MW-1:0]  w_low;
    logic           w_last;

    // In FIX the low chunk of the partial result is fed back inverted, giving ~r + 1 across the chain
    always_comb begin
        w_op_a = (r_state == FIX) ? ~r_low[CHUNK-1:0] : r_a[CHUNK-1:0];
        w_op_b = (r_state == FIX) ? '0 : r_b[CHUNK-1:0] ^ {CHUNK{r_sub}};
        w_sum  = {1'b0, w_op_a} + {1'b0, w_op_b} + (CHUNK+1)'(r_carry);
        w_low  = (r_low >> CHUNK) | (MW'(w_sum[CHUNK-1:0]) << (MW - CHUNK));
        w_last = (r_cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_low    <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a     <= man_a;
                    r_b     <= man_b;
                    r_sub   <= sub;
                    r_carry <= sub;
                    r_cnt   <= '0;
                    r_state <= CALC;
                end
                CALC: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_low   <= w_low;
                    r_carry <= w_sum[CHUNK];
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        if (r_sub && !w_sum[CHUNK]) begin
                            r_state <= FIX;
                            r_carry <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state  <= DONE;
                            r_valid  <= 1'b1;
                            r_result <= {w_sum[CHUNK] & ~r_sub, w_low};
                            r_neg    <= 1'b0;
                            r_zero   <= !(w_sum[CHUNK] & ~r_sub) && (w_low == '0);
                        end
                    end
                end
                FIX: begin
                    r_low   <= w_low;
                    r_carry <= w_sum[CHUNK];
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state  <= DONE;
                        r_valid  <= 1'b1;
                        r_result <= {1'b0, w_low};
                        r_neg    <= 1'b1;
                        r_zero   <= (w_low == '0);
                    end
                end
                DONE: if (out_ready) begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_valid;
    assign result    = r_result;
    assign neg       = r_neg;
    assign zero      = r_zero;
endmodule

// File: tb/tb_mantissa_addsub_seq.sv
// tb_mantissa_addsub_seq: directed and randomised checks of two mantissa_addsub_seq configurations.
module tb_mantissa_addsub_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iv7 = 1'b0, ir7, s7 = 1'b0, ov7, or7 = 1'b0, neg7, zero7;
    logic [6:0] a7 = '0, b7 = '0;
    logic [7:0] res7;
    logic       iv8 = 1'b0, ir8, s8 = 1'b0, ov8, or8 = 1'b0, neg8, zero8;
    logic [7:0] a8 = '0, b8 = '0;
    logic [8:0] res8;
    int         n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    mantissa_addsub_seq #(.MW(7), .CHUNK(1)) u_dut7 (
        .clk(clk), .rst(rst), .in_valid(iv7), .in_ready(ir7), .man_a(a7), .man_b(b7),
        .sub(s7), .out_valid(ov7), .out_ready(or7), .result(res7), .neg(neg7), .zero(zero7)
    );

    mantissa_addsub_seq #(.MW(8), .CHUNK(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .man_a(a8), .man_b(b8),
        .sub(s8), .out_valid(ov8), .out_ready(or8), .result(res8), .neg(neg8), .zero(zero8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic op7(input logic [6:0] a, input logic [6:0] b, input logic s,
                       input logic [7:0] er, input logic en, input int elat, input int hold);
        int n, lat;
        logic [7:0] r0;
        logic n0, z0;
        a7 = a; b7 = b; s7 = s; iv7 = 1'b1; or7 = 1'b0;
        n = 0;
        while (!ir7 && n < 100) begin @(posedge clk); #1; n++; end
        check("rdy7", 32'(ir7), 1);
        @(posedge clk); #1;
        iv7 = 1'b0;
        lat = 1;
        while (!ov7 && lat < 100) begin @(posedge clk); #1; lat++; end
        check("lat7", lat, elat);
        check("res7", 32'(res7), 32'(er));
        check("neg7", 32'(neg7), 32'(en));
        check("zero7", 32'(zero7), 32'(er == 8'h00));
        r0 = res7; n0 = neg7; z0 = zero7;
        for (int i = 0; i < hold; i++) begin
            iv7 = 1'b1; a7 = ~a; b7 = a; s7 = ~s;
            @(posedge clk); #1;
            check("hold_ov7", 32'(ov7), 1);
            check("hold_ir7", 32'(ir7), 0);
            check("hold_res7", {22'd0, n0, z0, r0}, {22'd0, neg7, zero7, res7});
        end
        iv7 = 1'b0; or7 = 1'b1;
        @(posedge clk); #1;
        or7 = 1'b0;
        check("clr7", 32'(ov7), 0);
        check("idle7", 32'(ir7), 1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [8:0] er, input logic en, input int elat);
        int n, lat;
        a8 = a; b8 = b; s8 = s; iv8 = 1'b1; or8 = 1'b0;
        n = 0;
        while (!ir8 && n < 100) begin @(posedge clk); #1; n++; end
        check("rdy8", 32'(ir8), 1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
        check("lat8", lat, elat);
        check("res8", 32'(res8), 32'(er));
        check("neg8", 32'(neg8), 32'(en));
        check("zero8", 32'(zero8), 32'(er == 9'h000));
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check("clr8", 32'(ov8), 0);
    endtask

    initial begin
        int a, b, s, r, ng;
        #1;
        check("rst_ir7", 32'(ir7), 0);
        check("rst_ov7", 32'(ov7), 0);
        check("rst_res7", 32'(res7), 0);
        check("rst_neg7", 32'(neg7), 0);
        check("rst_zero7", 32'(zero7), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("post_rst_ir7", 32'(ir7), 1);

        op7(7'h7F, 7'h01, 1'b0, 8'h80, 1'b0, 8, 0);
        op7(7'h50, 7'h20, 1'b1, 8'h30, 1'b0, 8, 0);
        op7(7'h20, 7'h50, 1'b1, 8'h30, 1'b1, 15, 0);
        op7(7'h33, 7'h33, 1'b1, 8'h00, 1'b0, 8, 0);
        op7(7'h00, 7'h00, 1'b0, 8'h00, 1'b0, 8, 0);
        op7(7'h20, 7'h50, 1'b1, 8'h30, 1'b1, 15, 5);
        op7(7'h05, 7'h03, 1'b0, 8'h08, 1'b0, 8, 0);

        // abandon an add in its 4th CALC cycle; outputs must clear without a clock edge
        a7 = 7'h7F; b7 = 7'h01; s7 = 1'b0; iv7 = 1'b1;
        @(posedge clk); #1;
        iv7 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_ov7", 32'(ov7), 0);
        check("arst_res7", 32'(res7), 0);
        check("arst_ir7", 32'(ir7), 0);
        #1 rst = 1'b0;
        #1;
        check("arst_rel_ir7", 32'(ir7), 1);
        op7(7'h10, 7'h01, 1'b1, 8'h0F, 1'b0, 8, 0);

        op8(8'h01, 8'hFF, 1'b1, 9'h0FE, 1'b1, 5);
        op8(8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b0, 3);
        op8(8'hA5, 8'hA5, 1'b1, 9'h000, 1'b0, 3);

        for (int k = 0; k < 1000; k++) begin
            a = int'($urandom_range(0, 127)); b = int'($urandom_range(0, 127)); s = int'($urandom_range(0, 1));
            r = s ? (a >= b ? a - b : b - a) : a + b;
            ng = (s == 1 && a < b) ? 1 : 0;
            op7(7'(a), 7'(b), 1'(s), 8'(r), 1'(ng), ng ? 15 : 8, 0);
        end
        for (int k = 0; k < 1000; k++) begin
            a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255)); s = int'($urandom_range(0, 1));
            r = s ? (a >= b ? a - b : b - a) : a + b;
            ng = (s == 1 && a < b) ? 1 : 0;
            op8(8'(a), 8'(b), 1'(s), 9'(r), 1'(ng), ng ? 5 : 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mantissa_addsub_seq.md
Name: mantissa_addsub_seq

Overview:
Multi-cycle, parametrised mantissa adder/subtractor for the FP add path. It processes CHUNK bits per cycle through a carry-chained slice. Unlike the current fixed 7-bit combinational add/sub, it returns a sign-magnitude result: on subtraction it outputs |A−B| plus a neg flag. It sits between exponent alignment (upstream) and normalisation (downstream), with valid/ready handshakes on both sides.

Parameters:
MW, 7, mantissa operand width in bits.
CHUNK, 1, bits processed per cycle; MW % CHUNK must be 0, otherwise elaboration fails (static assertion).

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands and mode valid.
in_ready  output  1  block can accept an operation.
man_a  input  MW  mantissa A, unsigned.
man_b  input  MW  mantissa B, unsigned.
sub  input  1  0 = A+B, 1 = A−B.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
result  output  MW+1  add: {carry, sum}; sub: magnitude, with result[MW] = 0.
neg  output  1  sub only: A < B, so result holds B−A.
zero  output  1  result == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - out_valid, result, neg, zero = 0.
  - in_ready = 0 while rst is high.
- N = MW/CHUNK.
- Accept: an operation is accepted when in_valid && in_ready on a rising edge. On accept, register man_a, man_b and sub. Set carry = sub. Clear the chunk counter.
- in_ready = (state == IDLE) && !rst. It is combinational from state only; there is no combinational in→out path.
- While not IDLE, in_valid and the operand ports are ignored.
- CALC (N cycles):
  - Slice i = A[i*CHUNK +: CHUNK] + (B[i*CHUNK +: CHUNK] ^ {CHUNK{sub}}) + carry.
  - Write the slice into the result register and update carry. Increment the counter.
  - After slice N−1, the final carry is known:
    - add → result[MW] = carry, go to DONE;
    - sub and carry = 1 (A ≥ B) → result[MW] = 0, go to DONE;
    - sub and carry = 0 (A < B) → go to FIX, set fix carry = 1, clear the counter.
- FIX (N cycles): slice i = ~r[slice i] + fix carry, chunk by chunk, i.e. two's-complement negation of the low MW bits. After the last slice: result[MW] = 0, neg = 1, go to DONE.
- DONE:
  - out_valid = 1. zero = (result == 0).
  - neg = 0 for every add and for every A ≥ B subtraction. A − A gives zero = 1, neg = 0.
  - result, neg and zero hold stable while out_valid && !out_ready.
  - On out_ready: clear out_valid, go to IDLE. Accept of the next operation is possible on the following edge.
- Latency (accept edge to first cycle with out_valid high):
  - add and non-negative sub: N+1 cycles;
  - negative sub: 2N+1 cycles.
- Throughput: one operation per ≥ N+2 cycles (N+2 is the minimum, reached with out_ready = 1 at DONE).
- Reset mid-operation (any state): the operation is abandoned with no output. All outputs return to reset values immediately (asynchronously). in_ready = 1 on the first cycle after rst deasserts.
- Width rules: the add carry is never lost (MW+1-bit result). A sub result never exceeds 2^MW − 1.
- out_ready while out_valid = 0 is ignored.

Test Plan:
1. MW=7, CHUNK=1, add, A=7'h7F, B=7'h01 → result=8'h80, neg=0, zero=0; out_valid 8 cycles after accept.
2. Sub, A=7'h50, B=7'h20 → result=8'h30, neg=0; latency 8. Sub A=7'h20, B=7'h50 → result=8'h30, neg=1; latency 15.
3. Sub, A=B=7'h33 → result=0, zero=1, neg=0. Add A=B=0 → result=0, zero=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid, driving in_valid=1 with new operands → result/neg/zero unchanged, in_ready=0, new operands not captured. Release out_ready → next op accepted one cycle after the handshake, with the correct result.
5. Assert rst during the 4th CALC cycle → out_valid=0 and result=0 immediately. After deassert: in_ready=1, and the op A=7'h10−B=7'h01 gives 8'h0F.
6. MW=8, CHUNK=4, sub A=8'h01, B=8'hFF → result=9'h0FE, neg=1, latency 5. Add A=8'hFF, B=8'hFF → 9'h1FE, latency 3. Random 1000-op sweep against a reference model for both configurations.
